// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC burst capture block: state encoding, default sizing
// and the timer-width helper.
package adc_cap_pkg;

    localparam int unsigned DEF_DATA_W        = 8;
    localparam int unsigned DEF_BURST_LEN     = 1024;
    localparam int unsigned DEF_RST_CYCLES    = 16;
    localparam int unsigned DEF_SETTLE_CYCLES = 8;
    localparam int unsigned DEF_CNT_W         = 11;
    localparam int unsigned STATE_W           = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } cap_state_e;

    // Bits needed to count 0 .. max(a, b) - 1, never less than one.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/adc_burst_capture.sv
// Flushes the Ethernet TX FIFO on start, lets it settle, then writes one burst of ADC samples.
// Optional ADC_TESTPAT_EN adds test_mode, which swaps the sample stream for a write counter.
module adc_burst_capture
    import adc_cap_pkg::*;
#(
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned BURST_LEN     = DEF_BURST_LEN,
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] addata,
`ifdef ADC_TESTPAT_EN
    input  logic              test_mode,
`endif
    input  logic              fifo_full,
    output logic              fifo_rst,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  sample_count,
    output logic [2:0]        state
);

    localparam int unsigned      TMR_W       = timer_width(RST_CYCLES, SETTLE_CYCLES);
    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BURST_LEN - 1);

    cap_state_e        state_q;
    cap_state_e        state_d;
    logic [TMR_W-1:0]  timer_q;
    logic [TMR_W-1:0]  timer_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              ovf_d;
    logic              wr_en;
    logic [DATA_W-1:0] samp_q;
    logic [DATA_W-1:0] cap_data;

    // Next-state, timer, counter and write decision.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = sample_count;
        ovf_d   = overflow;
        wr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FLUSH;
                    timer_d = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (timer_q == RST_LAST) begin
                    state_d = ST_SETTLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = ST_CAPTURE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_CAPTURE: begin
                // fifo_full gates the strobe in the same cycle; a full cycle drops its sample.
                if (!fifo_full) begin
                    wr_en = 1'b1;
                    if (sample_count != CNT_FULL) begin
                        cnt_d = sample_count + CNT_W'(1);
                    end
                    if (sample_count == CNT_LAST) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    ovf_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register plus registered status outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            sample_count <= '0;
            overflow     <= 1'b0;
            fifo_rst     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            samp_q       <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            sample_count <= cnt_d;
            overflow     <= ovf_d;
            fifo_rst     <= (state_d == ST_FLUSH);
            busy         <= (state_d == ST_FLUSH) || (state_d == ST_SETTLE) ||
                            (state_d == ST_CAPTURE);
            done         <= (state_d == ST_DONE);
            samp_q       <= addata;
        end
    end

`ifdef ADC_TESTPAT_EN
    logic [DATA_W-1:0] tp_cnt;

    // Pattern restarts at zero on entry to CAPTURE and steps only on accepted writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            tp_cnt <= '0;
        end else if ((state_q != ST_CAPTURE) && (state_d == ST_CAPTURE)) begin
            tp_cnt <= '0;
        end else if (wr_en) begin
            tp_cnt <= tp_cnt + DATA_W'(1);
        end
    end

    assign cap_data = test_mode ? tp_cnt : samp_q;
`else
    assign cap_data = samp_q;
`endif

    assign fifo_wr_en = wr_en;
    assign fifo_din   = wr_en ? cap_data : '0;
    assign state      = 3'(state_q);

endmodule

// File: tb/tb_adc_burst_capture.sv
// Scoreboard bench for adc_burst_capture with a short burst configuration.
// Define ADC_TESTPAT_EN for both files to also exercise the test-pattern path.
module tb_adc_burst_capture;
    import adc_cap_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned BL = 16;
    localparam int unsigned RC = 4;
    localparam int unsigned SC = 2;
    localparam int unsigned CW = 11;
    localparam int          FIRST_WR = 1 + RC + SC;

    typedef struct {
        int          cyc;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] addata;
    logic          test_mode;
    logic          fifo_full;
    logic          fifo_rst;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_din;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [CW-1:0] sample_count;
    logic [2:0]    state;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   obs_rst_cnt, obs_wr_cnt, obs_done_cnt, obs_done_k, seq_bad, exp_done_k;

    adc_burst_capture #(
        .DATA_W(DW), .BURST_LEN(BL), .RST_CYCLES(RC), .SETTLE_CYCLES(SC), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .addata(addata),
`ifdef ADC_TESTPAT_EN
        .test_mode(test_mode),
`endif
        .fifo_full(fifo_full),
        .fifo_rst(fifo_rst),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .sample_count(sample_count),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one burst cycle by cycle (k = 0 is the start cycle), pushing each expected
    // write and popping it when the DUT strobes fifo_wr_en. Returns after the DONE cycle,
    // or after the cycle in which rst is asserted.
    task automatic run_burst(input int full_at, input int full_len, input bit ramp, input bit tp,
                             input int extra_a, input int extra_b, input bit start_in_done,
                             input int rst_at);
        int            writes;
        int            kd;
        logic [DW-1:0] prev;
        logic [DW-1:0] cur;
        exp_t          e;
        exp_t          o;
        writes = 0;
        kd = 1000000;
        prev = '0;
        obs_rst_cnt = 0; obs_wr_cnt = 0; obs_done_cnt = 0; obs_done_k = -1; seq_bad = 0;
        exp_q.delete();
        for (int k = 0; k < 80; k++) begin
            cur       = ramp ? DW'(48 + k) : DW'(8);
            addata    = cur;
            start     = (k == 0) || (k == extra_a) || (k == extra_b) || (start_in_done && k == kd);
            fifo_full = (k >= full_at) && (k < full_at + full_len);
            rst       = (k == rst_at);
            test_mode = tp;
            if (k >= FIRST_WR && writes < int'(BL) && !fifo_full && (rst_at < 0 || k <= rst_at)) begin
                e.cyc  = k;
                e.data = tp ? DW'(writes) : prev;
                exp_q.push_back(e);
                writes++;
                if (writes == int'(BL)) kd = k + 1;
            end
            prev = cur;
            @(negedge clk);
            if (fifo_rst !== (k >= 1 && k <= int'(RC) && (rst_at < 0 || k <= rst_at))) seq_bad++;
            if (busy !== (k >= 1 && k < kd && (rst_at < 0 || k <= rst_at))) seq_bad++;
            if (done !== (k == kd)) seq_bad++;
            if (fifo_rst) obs_rst_cnt++;
            if (done) begin
                obs_done_cnt++;
                obs_done_k = k;
            end
            if (fifo_wr_en) begin
                obs_wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_write k=%0d din=%h required no write", k, fifo_din);
                end else begin
                    o = exp_q.pop_front();
                    if (o.cyc !== k || o.data !== fifo_din) begin
                        errors++;
                        $display("FAIL write k=%0d din=%h required k=%0d din=%h", k, fifo_din, o.cyc, o.data);
                    end
                end
            end
            @(posedge clk);
            #1;
            start = 1'b0; rst = 1'b0; fifo_full = 1'b0;
            if (rst_at >= 0 ? (k == rst_at) : (k == kd)) break;
        end
        exp_done_k = kd;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; addata = 8'hA5; fifo_full = 1'b0; test_mode = 1'b0;
        idle(5);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (fifo_rst !== 1'b0) begin errors++; $display("FAIL reset_fifo_rst got %b want 0", fifo_rst); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); end
        checks++; if (fifo_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h want 00", fifo_din); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (sample_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", sample_count); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic_burst;
        run_burst(-10, 0, 1'b0, 1'b0, -1, -1, 1'b0, -1);
        checks++; if (obs_rst_cnt !== int'(RC)) begin errors++; $display("FAIL basic_rst_window got %0d want %0d", obs_rst_cnt, RC); end
        checks++; if (seq_bad !== 0) begin errors++; $display("FAIL basic_sequence got %0d bad cycles want 0", seq_bad); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_missing got %0d unwritten want 0", exp_q.size()); end
        checks++; if (obs_wr_cnt !== int'(BL)) begin errors++; $display("FAIL basic_writes got %0d want %0d", obs_wr_cnt, BL); end
        checks++; if (obs_done_cnt !== 1 || obs_done_k !== exp_done_k) begin errors++; $display("FAIL basic_done got %0d at %0d want 1 at %0d", obs_done_cnt, obs_done_k, exp_done_k); end
        checks++; if (sample_count !== CW'(BL)) begin errors++; $display("FAIL basic_count got %0d want %0d", sample_count, BL); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got %b want 0", overflow); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL basic_idle got %0d want 0", state); end
    endtask

    task automatic test_ramp;
        run_burst(-10, 0, 1'b1, 1'b0, -1, -1, 1'b0, -1);
        checks++; if (exp_q.size() !== 0 || obs_wr_cnt !== int'(BL)) begin errors++; $display("FAIL ramp_writes got %0d want %0d", obs_wr_cnt, BL); end
        checks++; if (seq_bad !== 0) begin errors++; $display("FAIL ramp_sequence got %0d bad cycles want 0", seq_bad); end
    endtask

    task automatic test_backpressure;
        run_burst(12, 3, 1'b1, 1'b0, -1, -1, 1'b0, -1);
        checks++; if (exp_q.size() !== 0 || obs_wr_cnt !== int'(BL)) begin errors++; $display("FAIL bp_writes got %0d want %0d", obs_wr_cnt, BL); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b want 1", overflow); end
        checks++; if (obs_done_cnt !== 1 || obs_done_k !== exp_done_k) begin errors++; $display("FAIL bp_done got %0d at %0d want 1 at %0d", obs_done_cnt, obs_done_k, exp_done_k); end
        checks++; if (seq_bad !== 0) begin errors++; $display("FAIL bp_sequence got %0d bad cycles want 0", seq_bad); end
        checks++; if (sample_count !== CW'(BL)) begin errors++; $display("FAIL bp_count got %0d want %0d", sample_count, BL); end
    endtask

    task automatic test_start_busy;
        run_burst(12, 2, 1'b1, 1'b0, 5, 10, 1'b1, -1);
        checks++; if (obs_rst_cnt !== int'(RC)) begin errors++; $display("FAIL busy_rst_window got %0d want %0d", obs_rst_cnt, RC); end
        checks++; if (exp_q.size() !== 0 || obs_wr_cnt !== int'(BL)) begin errors++; $display("FAIL busy_writes got %0d want %0d", obs_wr_cnt, BL); end
        checks++; if (seq_bad !== 0) begin errors++; $display("FAIL busy_sequence got %0d bad cycles want 0", seq_bad); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL busy_overflow got %b want 1", overflow); end
        // Back-to-back: start in the IDLE cycle right after DONE.
        run_burst(-10, 0, 1'b1, 1'b0, -1, -1, 1'b0, -1);
        checks++; if (obs_rst_cnt !== int'(RC)) begin errors++; $display("FAIL b2b_rst_window got %0d want %0d", obs_rst_cnt, RC); end
        checks++; if (exp_q.size() !== 0 || obs_wr_cnt !== int'(BL)) begin errors++; $display("FAIL b2b_writes got %0d want %0d", obs_wr_cnt, BL); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b want 0", overflow); end
        checks++; if (seq_bad !== 0) begin errors++; $display("FAIL b2b_sequence got %0d bad cycles want 0", seq_bad); end
    endtask

    task automatic test_reset_mid;
        int late;
        late = 0;
        run_burst(-10, 0, 1'b1, 1'b0, -1, -1, 1'b0, FIRST_WR + 5);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rmid_state got %0d want 0", state); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rmid_wr_en got %b want 0", fifo_wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        checks++; if (sample_count !== '0) begin errors++; $display("FAIL rmid_count got %0d want 0", sample_count); end
        checks++; if (exp_q.size() !== 0 || obs_wr_cnt !== 6) begin errors++; $display("FAIL rmid_writes got %0d want 6", obs_wr_cnt); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || fifo_wr_en || fifo_rst) late++;
            @(posedge clk);
            #1;
        end
        checks++; if (obs_done_cnt !== 0 || late !== 0) begin errors++; $display("FAIL rmid_quiet got %0d done %0d late want 0 0", obs_done_cnt, late); end
    endtask

`ifdef ADC_TESTPAT_EN
    task automatic test_testpat;
        run_burst(12, 1, 1'b1, 1'b1, -1, -1, 1'b0, -1);
        checks++; if (exp_q.size() !== 0 || obs_wr_cnt !== int'(BL)) begin errors++; $display("FAIL tp_writes got %0d want %0d", obs_wr_cnt, BL); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL tp_overflow got %b want 1", overflow); end
        test_mode = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; addata = '0; fifo_full = 1'b0; test_mode = 1'b0;
        test_reset;
        test_basic_burst;
        idle(3);
        test_ramp;
        idle(2);
        test_backpressure;
        idle(2);
        test_start_busy;
        idle(2);
        test_reset_mid;
`ifdef ADC_TESTPAT_EN
        idle(2);
        test_testpat;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
